// File: rtl/program_feeder.sv
// Sequential program source for the pratica2 din/run/done handshake, with a WAIT watchdog.
// Optional FEEDER_STEP_EN adds a `step` input that gates each NEXT->ISSUE/FIN advance.
module program_feeder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              abort,
    input  logic              done,
`ifdef FEEDER_STEP_EN
    input  logic              step,
`endif
    output logic [DATA_W-1:0] din,
    output logic              run,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [ADDR_W-1:0] ptr
);

    localparam int              TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TMAX  = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] A0  = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FIN,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_din;
    logic                r_run;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_busy;
    logic                r_fin;
    logic                r_err;
    logic [TW-1:0]       r_timer;
    logic [ADDR_W:0]     r_len;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_din_nxt;
    logic                w_run_nxt;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [TW-1:0]       w_timer_nxt;
    logic [ADDR_W:0]     w_len_nxt;
    logic                w_busy_nxt;
    logic                w_fin_nxt;
    logic                w_err_nxt;
    logic                w_loadable;
    logic                w_start_ok;
    logic                w_last;
    logic                w_step_ok;
    logic [ADDR_W-1:0]   w_ptr_inc;
    logic [ADDR_W:0]     w_len_clamp;

`ifdef FEEDER_STEP_EN
    assign w_step_ok = step;
`else
    assign w_step_ok = 1'b1;
`endif

    assign w_loadable  = (r_state == S_IDLE) || (r_state == S_FIN) || (r_state == S_ERR);
    assign w_start_ok  = start && (prog_len != '0);
    // Oversized lengths are clamped so the pointer can never wrap past the last word.
    assign w_len_clamp = (prog_len > DEPTH) ? DEPTH : prog_len;
    assign w_ptr_inc   = r_ptr + 1'b1;
    assign w_last      = ({1'b0, r_ptr} == (r_len - 1'b1));

    // Program memory: no reset, writable only while the sequencer is parked.
    always_ff @(posedge clock) begin
        if (load_we && w_loadable) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_din_nxt   = r_din;
        w_run_nxt   = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_timer_nxt = r_timer;
        w_len_nxt   = r_len;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_FIN, S_ERR: begin
                    if (w_start_ok) begin
                        w_len_nxt   = w_len_clamp;
                        w_ptr_nxt   = '0;
                        w_din_nxt   = r_mem[A0];
                        w_run_nxt   = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // Watchdog fires on the TIMEOUT-th WAIT cycle without done.
                    if (done) begin
                        w_state_nxt = S_NEXT;
                    end else if (r_timer == TMAX) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (w_step_ok) begin
                        if (w_last) begin
                            w_state_nxt = S_FIN;
                        end else begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_din_nxt   = r_mem[w_ptr_inc];
                            w_run_nxt   = 1'b1;
                            w_state_nxt = S_ISSUE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        w_busy_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT) ||
                     (w_state_nxt == S_NEXT);
        w_fin_nxt  = (w_state_nxt == S_FIN);
        w_err_nxt  = (w_state_nxt == S_ERR);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_din   <= '0;
            r_run   <= 1'b0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            r_err   <= 1'b0;
            r_timer <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_din   <= w_din_nxt;
            r_run   <= w_run_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= w_busy_nxt;
            r_fin   <= w_fin_nxt;
            r_err   <= w_err_nxt;
            r_timer <= w_timer_nxt;
            r_len   <= w_len_nxt;
        end
    end

    assign din      = r_din;
    assign run      = r_run;
    assign busy     = r_busy;
    assign finished = r_fin;
    assign error    = r_err;
    assign ptr      = r_ptr;

endmodule

// File: tb/tb_program_feeder.sv
// Self-checking bench for program_feeder: random programs against a word-list model,
// with a responder that answers each run strobe after a chosen delay.
module tb_program_feeder;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 8;
    localparam int DEPTH   = 16;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              load_we = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [DATA_W-1:0] load_data = '0;
    logic [ADDR_W:0]   prog_len = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              done = 1'b0;
`ifdef FEEDER_STEP_EN
    logic              step = 1'b1;
`endif
    logic [DATA_W-1:0] din;
    logic              run;
    logic              busy;
    logic              finished;
    logic              error;
    logic [ADDR_W-1:0] ptr;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] cap_din [$];
    int                cap_ptr [$];
    int                run_cnt = 0;
    int                din_glitch = 0;
    logic [DATA_W-1:0] last_din = '0;
    int                resp_delay = 2;
    bit                resp_on = 1'b1;
    int                cd = 0;

    program_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .abort(abort),
        .done(done),
`ifdef FEEDER_STEP_EN
        .step(step),
`endif
        .din(din), .run(run), .busy(busy), .finished(finished), .error(error), .ptr(ptr)
    );

    always #5 clock = ~clock;

    // Processor stand-in: one-cycle done pulse resp_delay cycles after each run.
    always @(negedge clock) begin
        if (!resetn) begin
            cd = 0;
            done = 1'b0;
        end else if (run && resp_on) begin
            cd = resp_delay;
            done = 1'b0;
        end else if (cd > 0) begin
            cd = cd - 1;
            done = (cd == 0);
        end else begin
            done = 1'b0;
        end
    end

    // Issue log: every run strobe with its word and pointer; din must not move while waiting.
    always @(negedge clock) begin
        if (run) begin
            cap_din.push_back(din);
            cap_ptr.push_back(int'(ptr));
            run_cnt = run_cnt + 1;
            last_din = din;
        end else if (busy && din !== last_din) begin
            din_glitch = din_glitch + 1;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; start = 1'b0; abort = 1'b0; load_we = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic load_word(input int a, input logic [DATA_W-1:0] d, input bit takes_effect);
        load_we = 1'b1; load_addr = a[ADDR_W-1:0]; load_data = d;
        tick();
        load_we = 1'b0;
        if (takes_effect) model_mem[a] = d;
    endtask

    task automatic start_prog(input int len);
        prog_len = len[ADDR_W:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (finished || error) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Mismatches between the issues logged since `base` and model words 0..len-1.
    function automatic int seq_errs(input int base, input int len);
        int n = 0;
        if (run_cnt - base != len) n += 1000;
        for (int i = 0; i < len && base + i < cap_din.size(); i++) begin
            if (cap_din[base + i] !== model_mem[i]) n++;
            if (cap_ptr[base + i] != i) n++;
        end
        return n;
    endfunction

    task automatic test_reset();
        checks++;
        if (din !== '0 || run !== 1'b0 || ptr !== '0) begin
            errors++;
            $display("FAIL reset_data: din=%h run=%b ptr=%0d, want 0/0/0", din, run, ptr);
        end
        checks++;
        if (busy !== 1'b0 || finished !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b finished=%b error=%b, want 000", busy, finished, error);
        end
    endtask

    task automatic test_basic();
        int base; bit ok;
        resp_on = 1'b1; resp_delay = 2;
        load_word(0, 16'h1040, 1'b1);
        load_word(1, 16'h0005, 1'b1);
        load_word(2, 16'h2011, 1'b1);
        base = run_cnt;
        start_prog(3);
        checks++;
        if (run !== 1'b1 || din !== 16'h1040) begin
            errors++;
            $display("FAIL basic_first_issue: run=%b din=%h, want 1/1040", run, din);
        end
        wait_end(200, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: no finish, want finish"); end
        checks++;
        if (run_cnt - base !== 3) begin
            errors++;
            $display("FAIL basic_run_count: got %0d want 3", run_cnt - base);
        end
        checks++;
        if (seq_errs(base, 3) !== 0) begin
            errors++;
            $display("FAIL basic_sequence: %0d mismatches, want 0", seq_errs(base, 3));
        end
        checks++;
        if (finished !== 1'b1 || ptr !== 4'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: finished=%b ptr=%0d busy=%b, want 1/2/0", finished, ptr, busy);
        end
    endtask

    task automatic test_timeout();
        bit early; bit ok; int base;
        load_word(0, 16'($urandom()), 1'b1);
        resp_on = 1'b0;
        start_prog(1);
        early = 1'b0;
        // Cycles 1..TIMEOUT after entering WAIT must still show error low.
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (error) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: early=%b busy=%b, want 0/1", early, busy);
        end
        tick();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || ptr !== '0) begin
            errors++;
            $display("FAIL timeout_error: error=%b busy=%b ptr=%0d, want 1/0/0", error, busy, ptr);
        end
        resp_on = 1'b1; resp_delay = 3;
        base = run_cnt;
        start_prog(1);
        checks++;
        if (run !== 1'b1 || din !== model_mem[0] || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_restart: run=%b din=%h error=%b, want 1/%h/0", run, din, error, model_mem[0]);
        end
        wait_end(100, ok);
        checks++;
        if (ok !== 1'b1 || finished !== 1'b1 || seq_errs(base, 1) !== 0) begin
            errors++;
            $display("FAIL timeout_rerun: ok=%b finished=%b seqerr=%0d, want 1/1/0", ok, finished, seq_errs(base, 1));
        end
    endtask

    task automatic test_abort();
        int base;
        for (int i = 0; i < 4; i++) load_word(i, 16'($urandom()), 1'b1);
        resp_on = 1'b1; resp_delay = 5;
        base = run_cnt;
        start_prog(4);
        for (int i = 0; i < 100; i++) begin
            if (run_cnt - base >= 2) break;
            tick();
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || run !== 1'b0 || ptr !== 4'd1 || din !== model_mem[1]) begin
            errors++;
            $display("FAIL abort_state: busy=%b run=%b ptr=%0d din=%h, want 0/0/1/%h", busy, run, ptr, din, model_mem[1]);
        end
        repeat (8) tick();
        checks++;
        if (run_cnt - base !== 2 || busy !== 1'b0 || finished !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: runs=%0d busy=%b finished=%b, want 2/0/0", run_cnt - base, busy, finished);
        end
    endtask

    task automatic test_busy_write();
        int base; bit ok;
        resp_delay = 2;
        start_prog(3);
        load_word(0, 16'hFFFF, 1'b0);
        wait_end(200, ok);
        base = run_cnt;
        start_prog(3);
        wait_end(200, ok);
        checks++;
        if (ok !== 1'b1 || seq_errs(base, 3) !== 0) begin
            errors++;
            $display("FAIL busy_write_ignored: ok=%b seqerr=%0d, want 1/0", ok, seq_errs(base, 3));
        end
        base = run_cnt;
        start_prog(0);
        repeat (6) tick();
        checks++;
        if (run_cnt - base !== 0 || finished !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_start: runs=%0d finished=%b busy=%b, want 0/1/0", run_cnt - base, finished, busy);
        end
    endtask

    task automatic test_full();
        int base; bit ok;
        for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom()), 1'b1);
        resp_delay = int'($urandom_range(1, 4));
        base = run_cnt;
        start_prog(DEPTH);
        wait_end(1000, ok);
        checks++;
        if (ok !== 1'b1 || seq_errs(base, DEPTH) !== 0) begin
            errors++;
            $display("FAIL full_sequence: ok=%b seqerr=%0d, want 1/0", ok, seq_errs(base, DEPTH));
        end
        checks++;
        if (ptr !== 4'd15 || finished !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL full_end: ptr=%0d finished=%b error=%b, want 15/1/0", ptr, finished, error);
        end
    endtask

    task automatic test_random();
        int base; int len; int g0; bit ok;
        for (int it = 0; it < 6; it++) begin
            len = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < len; i++) load_word(i, 16'($urandom()), 1'b1);
            resp_delay = int'($urandom_range(1, TIMEOUT - 1));
            base = run_cnt;
            g0 = din_glitch;
            start_prog(len);
            wait_end(1000, ok);
            checks++;
            if (ok !== 1'b1 || seq_errs(base, len) !== 0 || ptr !== 4'(len - 1) || finished !== 1'b1) begin
                errors++;
                $display("FAIL random_prog%0d: len=%0d ok=%b seqerr=%0d ptr=%0d finished=%b, want ok seq0 ptr=%0d fin",
                         it, len, ok, seq_errs(base, len), ptr, finished, len - 1);
            end
            checks++;
            if (din_glitch - g0 !== 0) begin
                errors++;
                $display("FAIL random_din_stable%0d: %0d changes while waiting, want 0", it, din_glitch - g0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base; bit ok;
        resp_delay = 5;
        start_prog(3);
        tick();
        resetn = 1'b0;
        #1;
        checks++;
        if ({din, run, ptr, busy, finished, error} !== '0) begin
            errors++;
            $display("FAIL async_reset: din=%h run=%b ptr=%0d busy=%b fin=%b err=%b, want all 0",
                     din, run, ptr, busy, finished, error);
        end
        tick();
        resetn = 1'b1;
        tick();
        base = run_cnt;
        start_prog(3);
        wait_end(200, ok);
        checks++;
        if (ok !== 1'b1 || seq_errs(base, 3) !== 0) begin
            errors++;
            $display("FAIL reset_keeps_mem: ok=%b seqerr=%0d, want 1/0", ok, seq_errs(base, 3));
        end
    endtask

`ifdef FEEDER_STEP_EN
    task automatic test_step();
        int base; bit ok;
        for (int i = 0; i < 3; i++) load_word(i, 16'($urandom()), 1'b1);
        resp_delay = 2;
        step = 1'b0;
        base = run_cnt;
        start_prog(3);
        repeat (15) tick();
        checks++;
        if (run_cnt - base !== 1 || busy !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL step_hold: runs=%0d busy=%b error=%b, want 1/1/0", run_cnt - base, busy, error);
        end
        step = 1'b1;
        tick();
        checks++;
        if (run_cnt - base !== 2) begin
            errors++;
            $display("FAIL step_release: runs=%0d, want 2", run_cnt - base);
        end
        wait_end(200, ok);
        checks++;
        if (ok !== 1'b1 || seq_errs(base, 3) !== 0) begin
            errors++;
            $display("FAIL step_sequence: ok=%b seqerr=%0d, want 1/0", ok, seq_errs(base, 3));
        end
    endtask
`endif

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_timeout();
        test_abort();
        test_busy_write();
        test_full();
        test_random();
        test_reset_mid();
`ifdef FEEDER_STEP_EN
        test_step();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: bench did not complete, want completion");
        $fatal(1);
    end

endmodule

// File: doc/program_feeder.md
# program_feeder

Sequential instruction/data source for the `pratica2` processor's `din`/`run`/`done` interface. It replaces hand-set switches as the producer end of that interface. A small program is written into an internal word memory, either from switches or from a bench. On `start`, the block presents the words one at a time on `din`, pulses `run`, and waits for `done` before advancing. A watchdog flags a processor that never answers.

## Interface
Parameters:
- `DATA_W`, 16, width of each program word and of `din`
- `ADDR_W`, 4, memory address width; depth = 2**ADDR_W
- `TIMEOUT`, 64, cycles allowed in WAIT before error (≥2)

Ports:
- `clock`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `load_we`  in  1  write strobe for program memory
- `load_addr`  in  ADDR_W  write address
- `load_data`  in  DATA_W  write data
- `prog_len`  in  ADDR_W+1  number of words to issue (0..2**ADDR_W); sampled at start
- `start`  in  1  one-cycle request to run the program from word 0
- `abort`  in  1  forces return to IDLE
- `done`  in  1  processor completion, level, from `pratica2`
- `din`  out  DATA_W  word presented to processor, registered
- `run`  out  1  one-cycle issue strobe, registered
- `busy`  out  1  high in ISSUE/WAIT/NEXT
- `finished`  out  1  high in FIN
- `error`  out  1  high in ERR
- `ptr`  out  ADDR_W  index of current word, for HEX display

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, FIN, ERR. All outputs are registered.
- Reset values: state=IDLE, `din`=0, `run`=0, `ptr`=0, `busy`=`finished`=`error`=0, timer=0, latched length=0. Memory contents are not reset.
- Memory writes:
  - Write `mem[load_addr] <= load_data` when `load_we` is high and state is IDLE, FIN or ERR.
  - Writes during `busy` are ignored.
- IDLE/FIN/ERR + `start`:
  - If `prog_len`=0: ignored, and the state is unchanged.
  - Otherwise: latch the length, `ptr`<=0, `din`<=`mem[0]`, `run`<=1, go to ISSUE.
- ISSUE (1 cycle): `run` is high. `done` is ignored. Next state is WAIT, with `run`<=0 and timer<=0.
- WAIT:
  - `din` is held stable.
  - `done`=1 → NEXT.
  - Else timer++. When timer reaches TIMEOUT-1 without `done` → ERR.
- NEXT (1 cycle):
  - If `ptr` = length-1 → FIN.
  - Else `ptr`<=`ptr`+1, `din`<=`mem[ptr+1]`, `run`<=1 → ISSUE.
- FIN: `finished`=1. Held until `start` or `abort`.
- ERR: `error`=1, `ptr` frozen. Left only via `start` (restart), `abort` or reset.
- `abort` has priority over every other input in every state. The next state is IDLE with `run`=0; `din` and `ptr` are held.
- `start` while `busy` is ignored.
- A length of 2**ADDR_W issues every word. `ptr` never wraps.

## Timing
- `start` sampled at edge N → `run`=1 and `din`=`mem[0]` during cycle N+1.
- Minimum word period is 3 cycles (ISSUE, WAIT with `done`, NEXT). `done` seen at WAIT edge M → next `run` at cycle M+2.
- `done` is sampled only in WAIT. If `done` is still high from a previous word, it advances on the first WAIT cycle. The processor must therefore drop `done` before or at the `run` strobe.
- Error latency: `error`=1 exactly TIMEOUT cycles after entering WAIT with `done` low throughout.
- Reset is asynchronous: asserting `resetn` mid-operation clears `run` and the state immediately, without waiting for a clock edge.

## Configuration
- `FEEDER_STEP_EN`:
  - When defined, an extra input `step` (1 bit) is added.
  - In NEXT, the block waits until `step`=1 before moving to ISSUE or FIN. `busy` stays high while waiting, and the watchdog is inactive.
  - This allows single-stepping from a KEY.
- Without the macro, there is no `step` port and NEXT always lasts exactly 1 cycle.

## Test plan
- Load 3 words (0x1040, 0x0005, 0x2011), `prog_len`=3, `start`; `done` pulses 2 cycles after each `run` → exactly 3 `run` pulses with `din` = the three words in order, then `finished`=1 and `ptr`=2.
- TIMEOUT=8, `prog_len`=1, `done` held 0 → `error`=1 exactly 8 cycles after entering WAIT. A following `start` restarts from word 0.
- `abort` asserted in WAIT of word 1 → IDLE the next cycle, `run` stays 0, `busy`=0, `ptr`=1.
- `load_we` to address 0 with data 0xFFFF while `busy` → `mem[0]` unchanged, verified by rerunning the program. `start` with `prog_len`=0 → no `run`.
- ADDR_W=4, `prog_len`=16 → 16 `run` pulses, final `ptr`=15, no wrap, `finished`=1.
- `resetn` dropped mid-WAIT → all outputs 0 immediately, before the next clock edge. With `FEEDER_STEP_EN` defined: no second `run` until `step` is pulsed.
